// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA output path.
// Produces hcount/vcount, sync/blank/active strobes, line/frame markers and a
// completed-frame counter, all in the pixel clock domain.
// Optional build macro VGA_SYNC_DELAY_EN: when defined, hsync_n/vsync_n/blank_n/
// active pass through a PIXEL_LATENCY-deep shift register so they line up with
// colour data from the downstream ROM stage; when undefined they are a
// zero-latency decode of the current counters.

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33,
    parameter int unsigned PIXEL_LATENCY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank_n,
    output logic       active,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter limits and decode boundaries; 11 bits so an end value of 1024 fits.
    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Control bus order: {active, blank_n, vsync_n, hsync_n}.
    localparam logic [3:0]  CTRL_IDLE   = 4'b0011;

    // Reject configurations the 10-bit counters or the pipeline cannot support.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIXEL_LATENCY < 1 || PIXEL_LATENCY > 4)
    begin : g_bad_cfg
        $error("vga_timing_gen: unsupported timing configuration");
    end

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic [7:0] r_frame_cnt;

    logic       w_line_end;
    logic       w_frame_end;
    logic       w_h_vis;
    logic       w_v_vis;
    logic       w_h_sync;
    logic       w_v_sync;
    logic [3:0] w_ctrl_dec;
    logic [3:0] w_ctrl_out;

    // Line/frame markers and raster region decode from the current counters.
    always_comb begin
        w_line_end  = (r_hcount == H_LAST);
        w_frame_end = w_line_end && (r_vcount == V_LAST);
        w_h_vis     = ({1'b0, r_hcount} < H_VIS_END);
        w_v_vis     = ({1'b0, r_vcount} < V_VIS_END);
        w_h_sync    = ({1'b0, r_hcount} >= H_SYNC_BEG) && ({1'b0, r_hcount} < H_SYNC_END);
        w_v_sync    = ({1'b0, r_vcount} >= V_SYNC_BEG) && ({1'b0, r_vcount} < V_SYNC_END);
        w_ctrl_dec  = {w_h_vis & w_v_vis, w_h_vis & w_v_vis, ~w_v_sync, ~w_h_sync};
    end

    // Raster counters: hcount every cycle, vcount only on the line wrap.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_line_end) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
        end else begin
            r_hcount <= r_hcount + 10'd1;
        end
    end

    // Completed-frame counter, bumped on the edge that ends the last pixel.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    localparam int unsigned LAST_STAGE = PIXEL_LATENCY - 1;

    logic [3:0] r_ctrl_pipe [PIXEL_LATENCY];

    // Delay pipeline; every stage holds the inactive pattern after reset.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i < int'(PIXEL_LATENCY); i++) begin
                r_ctrl_pipe[i] <= CTRL_IDLE;
            end
        end else begin
            r_ctrl_pipe[0] <= w_ctrl_dec;
            for (int i = 1; i < int'(PIXEL_LATENCY); i++) begin
                r_ctrl_pipe[i] <= r_ctrl_pipe[i-1];
            end
        end
    end

    // Oldest stage drives the connector controls.
    always_comb begin
        w_ctrl_out = r_ctrl_pipe[LAST_STAGE];
    end
`else
    // Zero-latency path straight from the decode.
    always_comb begin
        w_ctrl_out = w_ctrl_dec;
    end
`endif

    assign hcount    = r_hcount;
    assign vcount    = r_vcount;
    assign line_end  = w_line_end;
    assign frame_end = w_frame_end;
    assign frame_cnt = r_frame_cnt;
    assign hsync_n   = w_ctrl_out[0];
    assign vsync_n   = w_ctrl_out[1];
    assign blank_n   = w_ctrl_out[2];
    assign active    = w_ctrl_out[3];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a shrunken raster so that hundreds of
// frames fit in a short run. The reference model derives every expected output
// from the number of cycles elapsed since the last reset edge.
// Works with VGA_SYNC_DELAY_EN either defined or undefined.

module tb_vga_timing_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int VA  = 5;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int PL  = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

`ifdef VGA_SYNC_DELAY_EN
    localparam int LAT = PL;
`else
    localparam int LAT = 0;
`endif

    logic       vga_clk;
    logic       reset;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic       active;
    logic       line_end;
    logic       frame_end;
    logic [7:0] frame_cnt;

    int n_checks;
    int n_errors;
    int cyc;     // cycles since the most recent reset edge
    bit valid;   // model is synchronised once a reset edge has been seen

    vga_timing_gen #(
        .H_ACTIVE      (HA),
        .H_FP          (HFP),
        .H_SYNC        (HS),
        .H_BP          (HBP),
        .V_ACTIVE      (VA),
        .V_FP          (VFP),
        .V_SYNC        (VS),
        .V_BP          (VBP),
        .PIXEL_LATENCY (PL)
    ) dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .blank_n   (blank_n),
        .active    (active),
        .line_end  (line_end),
        .frame_end (frame_end),
        .frame_cnt (frame_cnt)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d since reset)", tag, got, exp,
                         cyc);
        end
    endtask

    // Compare every output against the raster rules for the current cycle.
    task automatic check_all();
        int h, v, p, hp, vp;
        bit vis, hsy, vsy;
        h = cyc % HT;
        v = (cyc / HT) % VT;
        check_eq("hcount", 32'(hcount), 32'(h));
        check_eq("vcount", 32'(vcount), 32'(v));
        check_eq("line_end", 32'(line_end), 32'(h == HT - 1));
        check_eq("frame_end", 32'(frame_end), 32'(h == HT - 1 && v == VT - 1));
        check_eq("frame_cnt", 32'(frame_cnt), 32'((cyc / FT) % 256));
        if (cyc < LAT) begin
            check_eq("hsync_n", 32'(hsync_n), 32'd1);
            check_eq("vsync_n", 32'(vsync_n), 32'd1);
            check_eq("blank_n", 32'(blank_n), 32'd0);
            check_eq("active", 32'(active), 32'd0);
        end else begin
            p   = cyc - LAT;
            hp  = p % HT;
            vp  = (p / HT) % VT;
            vis = (hp < HA) && (vp < VA);
            hsy = (hp >= HA + HFP) && (hp < HA + HFP + HS);
            vsy = (vp >= VA + VFP) && (vp < VA + VFP + VS);
            check_eq("hsync_n", 32'(hsync_n), 32'(!hsy));
            check_eq("vsync_n", 32'(vsync_n), 32'(!vsy));
            check_eq("blank_n", 32'(blank_n), 32'(vis));
            check_eq("active", 32'(active), 32'(vis));
        end
    endtask

    // One clock: drive reset, advance the model at the edge, check at negedge.
    task automatic step(input bit rst);
        reset = rst;
        @(posedge vga_clk);
        if (rst) begin
            cyc   = 0;
            valid = 1'b1;
        end else begin
            cyc++;
        end
        @(negedge vga_clk);
        if (valid) check_all();
    endtask

    initial begin
        int target;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        valid    = 1'b0;
        reset    = 1'b1;

        // Reset for three cycles, then run a couple of frames.
        repeat (3) step(1'b1);
        repeat (2 * FT + 5) step(1'b0);

        // One-cycle reset mid-frame, inside the horizontal sync of a visible line.
        target = 3 * HT + HA + HFP + 1;
        for (int i = 0; i < FT && (cyc % FT) != target; i++) step(1'b0);
        step(1'b1);
        repeat (FT + 3) step(1'b0);

        // Random run lengths interleaved with random reset bursts.
        repeat (40) begin
            repeat ($urandom_range(1, 2 * FT)) step(1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) step(1'b1);
            end
        end

        // 257 uninterrupted frames so frame_cnt wraps 255 -> 0.
        step(1'b1);
        repeat (257 * FT + 2) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA output path, clocked by the pixel clock. It produces the `hcount`/`vcount` raster coordinates consumed by the pixel/colour stage (ROM-addressed bitmap lookup). It also produces DAC/connector control signals (`hsync_n`, `vsync_n`, `blank_n`, `active`), delayed to line up with that stage's ROM read latency, plus line/frame markers and a frame counter for the game logic.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIXEL_LATENCY`, 1, cycles from `hcount`/`vcount` to valid colour at the downstream stage; legal range 1..4
- `vga_clk  in  1  pixel clock; the only clock`
- `reset  in  1  synchronous, active-high reset`
- `hcount  out  10  horizontal counter, 0..H_TOTAL-1`
- `vcount  out  10  vertical counter, 0..V_TOTAL-1`
- `hsync_n  out  1  horizontal sync, active low`
- `vsync_n  out  1  vertical sync, active low`
- `blank_n  out  1  low outside the visible area`
- `active  out  1  high inside the visible area; same alignment as blank_n`
- `line_end  out  1  high during the last pixel of each line`
- `frame_end  out  1  high during the last pixel of each frame`
- `frame_cnt  out  8  completed-frame count, wraps 255->0`

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024.
- Line layout: visible area first, then front porch, sync, back porch. Frame layout uses the same order.
- `hcount` and `vcount` are registers:
  - `hcount` increments every cycle and wraps from H_TOTAL-1 to 0.
  - `vcount` increments only on the `hcount` wrap and wraps from V_TOTAL-1 to 0.
  - At hcount=H_TOTAL-1 and vcount=V_TOTAL-1, both wrap on the same edge to (0,0).
- Decoded raster flags:
  - h_vis = hcount<H_ACTIVE
  - v_vis = vcount<V_ACTIVE
  - h_sync = H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (656..751)
  - v_sync = V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (490..491)
- Output mapping: active = h_vis&v_vis; blank_n = active; hsync_n = ~h_sync; vsync_n = ~v_sync.
- `line_end` and `frame_end` are decoded combinationally from the counters and are never delayed.
- `frame_cnt` increments on the edge that ends a `frame_end` cycle.
- Reset values:
  - hcount=0, vcount=0, frame_cnt=0, line_end=0, frame_end=0.
  - With delay compiled in: hsync_n=1, vsync_n=1, blank_n=0, active=0.
  - Without delay: outputs are decoded from (0,0), so hsync_n=1, vsync_n=1, blank_n=1, active=1.
- Reset mid-frame: on the next edge, counters return to 0, every delay-pipeline stage loads its inactive value, and frame_cnt clears. No partial frame is counted.

## Timing
- Counters: a new value every cycle, with no stalls.
- Delay pipeline (`VGA_SYNC_DELAY_EN` defined):
  - `hsync_n`, `vsync_n`, `blank_n` and `active` are exactly PIXEL_LATENCY cycles behind the counter value they decode.
  - Example: `blank_n` first falls PIXEL_LATENCY cycles after hcount=640.
- During the PIXEL_LATENCY cycles after reset release, delayed outputs show their reset (inactive) values.
- `line_end`/`frame_end` share the cycle with hcount=H_TOTAL-1 (and vcount=V_TOTAL-1 for `frame_end`).
- `frame_cnt` holds its new value from the first cycle of the next frame (hcount=0, vcount=0).

## Configuration
- `VGA_SYNC_DELAY_EN` defined:
  - A PIXEL_LATENCY-deep shift register delays `hsync_n`, `vsync_n`, `blank_n` and `active`, so they align with pixel data from the downstream ROM stage.
- Not defined:
  - Those four outputs are a combinational decode of the current counters, with zero latency and no shift register.
  - PIXEL_LATENCY is ignored.

## Test plan
- Reset for 3 cycles, then release: hcount=0, vcount=0, frame_cnt=0. With the macro and PIXEL_LATENCY=1, blank_n=0 on the first cycle and 1 on the second.
- Run one line (macro off):
  - hsync_n is low exactly for hcount 656..751 (96 cycles).
  - blank_n is low for hcount 640..799.
  - line_end is high only at hcount=799.
  - vcount steps 0->1 on the following edge.
- Run a full frame (macro off):
  - vsync_n is low for vcount 490..491 (1600 cycles).
  - frame_end pulses once after 420000 cycles.
  - frame_cnt goes 0->1 as the counters return to (0,0).
- Macro on, PIXEL_LATENCY=3:
  - hsync_n falls 3 cycles after hcount=656.
  - blank_n rises 3 cycles after the hcount 799->0 wrap of a visible line.
- Run 256 frames: frame_cnt wraps 255->0 without glitching the counters.
- Assert reset at hcount=700, vcount=300 for one cycle:
  - Next cycle hcount=0, vcount=0, frame_cnt=0.
  - Delayed outputs are inactive for PIXEL_LATENCY cycles.
  - Normal timing resumes with no short sync pulse.
